// File: rtl/zr_qspi_pkg.sv
// Shared types and constants for the QSPI execute-in-place read controller.
// Phase lengths are counted in SCK periods.
package zr_qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_GAP
  } qspi_state_e;

  localparam logic [7:0] QSPI_CMD_READ  = 8'h03;
  localparam logic [7:0] QSPI_CMD_QREAD = 8'h6B;

  localparam logic [5:0] QSPI_LEN_CMD         = 6'd8;
  localparam logic [5:0] QSPI_LEN_ADDR        = 6'd24;
  localparam logic [5:0] QSPI_LEN_DUMMY       = 6'd8;
  localparam logic [5:0] QSPI_LEN_DATA_SINGLE = 6'd32;
  localparam logic [5:0] QSPI_LEN_DATA_QUAD   = 6'd8;

  localparam logic [3:0] QSPI_OE_SINGLE  = 4'b1101;
  localparam logic [3:0] QSPI_OE_QUAD_IN = 4'b0000;

  // Index of the final SCK of a phase; idle states never see a falling strobe.
  function automatic logic [5:0] phase_last(input qspi_state_e st, input logic quad);
    logic [5:0] len;
    case (st)
      ST_CMD:   len = QSPI_LEN_CMD;
      ST_ADDR:  len = QSPI_LEN_ADDR;
      ST_DUMMY: len = QSPI_LEN_DUMMY;
      ST_DATA:  len = quad ? QSPI_LEN_DATA_QUAD : QSPI_LEN_DATA_SINGLE;
      default:  len = 6'd0;
    endcase
    return len - 6'd1;
  endfunction

endpackage

// File: rtl/zr_qspi_sck_gen.sv
// SPI mode-0 clock divider: sck_o low then high for CLK_DIV clk each.
// Strobes flag the clk edge on which sck_o will rise or fall.
module zr_qspi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic stop,
  output logic sck_o,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic          en;
  logic [CW-1:0] cnt;
  logic          tick;

  assign tick     = en && (cnt == TERM);
  assign rise_stb = tick && !sck_o;
  assign fall_stb = tick && sck_o;

  always_ff @(posedge clk) begin
    if (rst || stop) begin
      en    <= 1'b0;
      cnt   <= '0;
      sck_o <= 1'b0;
    end else if (run) begin
      en    <= 1'b1;
      cnt   <= '0;
      sck_o <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      sck_o <= ~sck_o;
    end else if (en) begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/zr_qspi_xip_ctrl.sv
// Read-only XIP controller: one 32-bit little-endian word per granted request via 0x03 or 0x6B.
// Result 1+2*CLK_DIV*N clk after grant (N=64 single, 48 quad); one request in flight, req_i held until gnt_o.
module zr_qspi_xip_ctrl
  import zr_qspi_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_HIGH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [23:0] addr_i,
  input  logic        quad_en_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        sck_o,
  output logic        cs_n_o,
  output logic [3:0]  dq_o,
  output logic [3:0]  dq_oe,
  input  logic [3:0]  dq_i
);

  qspi_state_e state, state_nxt;

  logic        quad;
  logic [5:0]  bit_cnt;
  logic [31:0] sout;
  logic [31:0] sin;
  logic [15:0] gap_cnt;
  logic [23:0] addr_al;
  logic        rise_stb, fall_stb;
  logic        phase_end, gap_done, grant_ok, start, stop_sck;

  assign addr_al   = addr_i & 24'hFF_FFFC;
  assign phase_end = fall_stb && (bit_cnt == phase_last(state, quad));
  assign gap_done  = (state == ST_GAP) && (gap_cnt == 16'(CS_HIGH - 1));
  // The last GAP cycle may already grant so the next gnt_o lands exactly CS_HIGH after rvalid_o.
  assign grant_ok  = req_i && !gnt_o && ((state == ST_IDLE) || gap_done);
  assign start     = (state == ST_IDLE) && gnt_o;
  assign stop_sck  = (state == ST_DATA) && phase_end;

  zr_qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .rst      (rst),
    .run      (start),
    .stop     (stop_sck),
    .sck_o    (sck_o),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (gnt_o)     state_nxt = ST_CMD;
      ST_CMD:   if (phase_end) state_nxt = ST_ADDR;
      ST_ADDR:  if (phase_end) state_nxt = quad ? ST_DUMMY : ST_DATA;
      ST_DUMMY: if (phase_end) state_nxt = ST_DATA;
      ST_DATA:  if (phase_end) state_nxt = ST_GAP;
      ST_GAP:   if (gap_done)  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // dq_o[3:2] held high keeps WP#/HOLD# inactive whenever those lanes are driven.
  always_comb begin
    cs_n_o = 1'b1;
    dq_oe  = QSPI_OE_QUAD_IN;
    dq_o   = 4'b0000;
    busy_o = gnt_o || (state != ST_IDLE);
    case (state)
      ST_CMD, ST_ADDR: begin
        cs_n_o = 1'b0;
        dq_oe  = QSPI_OE_SINGLE;
        dq_o   = {2'b11, 1'b0, sout[31]};
      end
      ST_DUMMY: cs_n_o = 1'b0;
      ST_DATA: begin
        cs_n_o = 1'b0;
        if (!quad) begin
          dq_oe = QSPI_OE_SINGLE;
          dq_o  = 4'b1100;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_o    <= 1'b0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      quad     <= 1'b0;
      bit_cnt  <= '0;
      sout     <= '0;
      sin      <= '0;
      gap_cnt  <= '0;
    end else begin
      gnt_o    <= grant_ok;
      rvalid_o <= stop_sck;

      if (grant_ok) begin
        quad <= quad_en_i;
        sout <= {(quad_en_i ? QSPI_CMD_QREAD : QSPI_CMD_READ), addr_al};
      end else if (fall_stb && ((state == ST_CMD) || (state == ST_ADDR))) begin
        sout <= {sout[30:0], 1'b0};
      end

      if (start)         bit_cnt <= '0;
      else if (fall_stb) bit_cnt <= phase_end ? 6'd0 : bit_cnt + 6'd1;

      if (rise_stb && (state == ST_DATA))
        sin <= quad ? {sin[27:0], dq_i} : {sin[30:0], dq_i[1]};

      // First byte received arrived in the top bits; swap to little-endian.
      if (stop_sck)
        rdata_o <= {sin[7:0], sin[15:8], sin[23:16], sin[31:24]};

      if (state == ST_GAP) gap_cnt <= gap_cnt + 16'd1;
      else                 gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_zr_qspi_xip_ctrl.sv
// Bench for zr_qspi_xip_ctrl: two instances (CLK_DIV 1 and 3) each wired to a behavioural SPI flash,
// directed and random reads compared against a word-level model of flash contents.
module tb_zr_qspi_xip_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic        req  [2];
  logic [23:0] addr [2];
  logic        quad [2];
  wire         gnt [2];
  wire         rvalid [2];
  wire  [31:0] rdata [2];
  wire         busy [2];
  wire         sck [2];
  wire         csn [2];
  wire  [3:0]  dqo [2];
  wire  [3:0]  dqoe [2];
  wire  [3:0]  dqi [2];
  wire  [7:0]  fcmd_w [2];
  wire  [23:0] faddr_w [2];
  wire  [7:0]  fbit_w [2];

  logic [7:0] mem [256];
  int gcnt [2];
  int rcnt [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (gnt[i] === 1'b1)    gcnt[i] = gcnt[i] + 1;
      if (rvalid[i] === 1'b1) rcnt[i] = rcnt[i] + 1;
    end
  end

  zr_qspi_xip_ctrl #(.CLK_DIV(1), .CS_HIGH(2)) dut1 (
    .clk(clk), .rst(rst), .req_i(req[0]), .addr_i(addr[0]), .quad_en_i(quad[0]),
    .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .busy_o(busy[0]),
    .sck_o(sck[0]), .cs_n_o(csn[0]), .dq_o(dqo[0]), .dq_oe(dqoe[0]), .dq_i(dqi[0])
  );

  zr_qspi_xip_ctrl #(.CLK_DIV(3), .CS_HIGH(2)) dut3 (
    .clk(clk), .rst(rst), .req_i(req[1]), .addr_i(addr[1]), .quad_en_i(quad[1]),
    .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .busy_o(busy[1]),
    .sck_o(sck[1]), .cs_n_o(csn[1]), .dq_o(dqo[1]), .dq_oe(dqoe[1]), .dq_i(dqi[1])
  );

  // Flash model: samples DI on SCK rise, drives data after SCK fall; 256-byte array wraps.
  for (genvar u = 0; u < 2; u++) begin : g_flash
    int          fbit = 0;
    logic [7:0]  fcmd = 8'h00;
    logic [23:0] faddr = 24'h0;
    logic [3:0]  fdq = 4'h0;
    assign dqi[u]     = fdq;
    assign fcmd_w[u]  = fcmd;
    assign faddr_w[u] = faddr;
    assign fbit_w[u]  = 8'(fbit);

    always @(posedge sck[u] or negedge csn[u]) begin
      if (sck[u] === 1'b0) fbit = 0;
      else if (csn[u] === 1'b0) begin
        if (fbit < 8)       fcmd  = {fcmd[6:0], dqo[u][0]};
        else if (fbit < 32) faddr = {faddr[22:0], dqo[u][0]};
        fbit = fbit + 1;
      end
    end

    always @(negedge sck[u]) begin
      int k;
      logic [7:0] b;
      if (csn[u] === 1'b0) begin
        if (fcmd == 8'h6B && fbit >= 40) begin
          k   = fbit - 40;
          b   = mem[(int'(faddr) + k / 2) & 255];
          fdq = (k % 2 == 0) ? b[7:4] : b[3:0];
        end else if (fcmd != 8'h6B && fbit >= 32) begin
          k   = fbit - 32;
          b   = mem[(int'(faddr) + k / 8) & 255];
          fdq = {2'b00, b[7 - (k % 8)], 1'b0};
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    int b;
    b = int'(a) & 32'hFFFF_FFFC;
    return {mem[(b + 3) & 255], mem[(b + 2) & 255], mem[(b + 1) & 255], mem[b & 255]};
  endfunction

  // Called and returns at a negedge; r is the cycle in which rvalid was seen.
  task automatic do_read(input int u, input logic [23:0] a, input logic q, output int r);
    int div, lat, g, t, hi_c, lo_c;
    logic oe_bad;
    logic [7:0] op;
    logic [31:0] ew;
    div = (u == 0) ? 1 : 3;
    lat = 1 + 2 * div * (q ? 48 : 64);
    op  = q ? 8'h6B : 8'h03;
    ew  = exp_word(a);
    req[u] = 1'b1; addr[u] = a; quad[u] = q;
    t = 0;
    while (gnt[u] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("gnt_seen", gnt[u], 1);
    g = cyc;
    req[u] = 1'b0; addr[u] = 24'($urandom); quad[u] = ~q;
    @(negedge clk);
    chk("cs_fall_g1", csn[u], 0);
    chk("sck_low_g1", sck[u], 0);
    chk("oe_cmd_g1", dqoe[u], 4'b1101);
    chk("dq_cmd_g1", dqo[u], {2'b11, 1'b0, op[7]});
    hi_c = -1; lo_c = -1; oe_bad = 1'b0; t = 0;
    while (rvalid[u] !== 1'b1 && t < lat + 20) begin
      if (sck[u] === 1'b1 && hi_c < 0) hi_c = cyc;
      if (sck[u] === 1'b0 && hi_c >= 0 && lo_c < 0) lo_c = cyc;
      if (fbit_w[u] >= 33 && csn[u] === 1'b0 && dqoe[u] !== (q ? 4'b0000 : 4'b1101)) oe_bad = 1'b1;
      @(negedge clk); t++;
    end
    r = cyc;
    chk("rvalid_seen", rvalid[u], 1);
    chk("latency", 64'(r - g), 64'(lat));
    chk("rdata", rdata[u], ew);
    chk("cs_high_r", csn[u], 1);
    chk("sck_low_r", sck[u], 0);
    chk("oe_off_r", dqoe[u], 4'b0000);
    chk("opcode", fcmd_w[u], op);
    chk("address", faddr_w[u], a & 24'hFF_FFFC);
    chk("sck_low_len", 64'(hi_c - (g + 1)), 64'(div));
    chk("sck_high_len", 64'(lo_c - hi_c), 64'(div));
    chk("oe_data_phase", oe_bad, 0);
    @(negedge clk);
    chk("busy_gap", busy[u], 1);
    @(negedge clk);
    chk("busy_done", busy[u], 0);
    chk("rdata_hold", rdata[u], ew);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r1, g2, t, gc, rc;
    logic [23:0] a2;
    logic q;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'haa; mem[1] = 8'h55; mem[2] = 8'h81; mem[3] = 8'h0f;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = 24'h0; quad[i] = 1'b0; gcnt[i] = 0; rcnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cs_n", csn[0], 1);
    chk("rst_sck", sck[0], 0);
    chk("rst_dq", dqo[0], 4'h0);
    chk("rst_oe", dqoe[0], 4'h0);
    chk("rst_gnt", gnt[0], 0);
    chk("rst_rvalid", rvalid[0], 0);
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_busy", busy[0], 0);
    chk("rst_cs_n_div3", csn[1], 1);

    do_read(0, 24'h000000, 1'b0, r);
    chk("word_single", rdata[0], 32'h0f8155aa);
    do_read(0, 24'h000000, 1'b1, r);
    chk("word_quad", rdata[0], 32'h0f8155aa);
    do_read(1, 24'h000006, 1'b0, r);
    do_read(1, 24'($urandom), 1'b1, r);

    for (int i = 0; i < 6; i++) begin
      q = 1'($urandom_range(0, 1));
      do_read(0, 24'($urandom), q, r);
    end

    // Back-to-back with req_i held high throughout.
    a2 = 24'($urandom);
    req[0] = 1'b1; addr[0] = 24'h000000; quad[0] = 1'b0;
    t = 0;
    while (gnt[0] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("b2b_gnt1", gnt[0], 1);
    addr[0] = a2;
    t = 0;
    while (rvalid[0] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    r1 = cyc;
    chk("b2b_rvalid1", rvalid[0], 1);
    chk("b2b_rdata1", rdata[0], 32'h0f8155aa);
    t = 0;
    while (gnt[0] !== 1'b1 && t < 20) begin
      chk("b2b_cs_gap", csn[0], 1);
      @(negedge clk); t++;
    end
    g2 = cyc;
    chk("b2b_gnt2_cycle", 64'(g2 - r1), 64'd2);
    chk("b2b_cs_at_g2", csn[0], 1);
    req[0] = 1'b0;
    @(negedge clk);
    chk("b2b_cs_fall", csn[0], 0);
    t = 0;
    while (rvalid[0] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    chk("b2b_latency2", 64'(cyc - g2), 64'd129);
    chk("b2b_rdata2", rdata[0], exp_word(a2));
    repeat (4) @(negedge clk);

    // Reset 20 clk after grant, mid-ADDR.
    rc = rcnt[0];
    req[0] = 1'b1; addr[0] = 24'h000010; quad[0] = 1'b0;
    t = 0;
    while (gnt[0] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("rst_mid_gnt", gnt[0], 1);
    req[0] = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", csn[0], 1);
    chk("abort_sck", sck[0], 0);
    chk("abort_oe", dqoe[0], 4'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("abort_no_rvalid", 64'(rcnt[0] - rc), 64'd0);
    do_read(0, 24'h000020, 1'b0, r);

    // Request pulsed while busy and withdrawn before IDLE.
    gc = gcnt[0]; rc = rcnt[0];
    req[0] = 1'b1; addr[0] = 24'h000040; quad[0] = 1'b1;
    t = 0;
    while (gnt[0] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    req[0] = 1'b0;
    repeat (30) @(negedge clk);
    req[0] = 1'b1;
    repeat (5) @(negedge clk);
    req[0] = 1'b0;
    repeat (200) @(negedge clk);
    chk("withdraw_gnt_count", 64'(gcnt[0] - gc), 64'd1);
    chk("withdraw_rvalid_count", 64'(rcnt[0] - rc), 64'd1);
    chk("withdraw_rdata", rdata[0], exp_word(24'h000040));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zr_qspi_xip_ctrl.md
# zr_qspi_xip_ctrl

Read-only execute-in-place controller for the SoC's external SPI flash. Accepts word read requests from the bus side on a req/gnt/rvalid handshake, serialises a flash READ (0x03) or Quad Output Fast Read (0x6B) command onto the `io_qspi_*` pads, and returns one 32-bit little-endian word per request. Sits between the boot/instruction fetch path and the QSPI pad ring, and sequences the flash model lanes `sck`, `cs_n` and `dq[3:0]`.

## Interface
- `CLK_DIV`, default 1: SCK half-period in `clk` cycles; legal range ≥1.
- `CS_HIGH`, default 2: minimum `clk` cycles `cs_n_o` stays high between transactions; legal range ≥1.
- `clk`  in  1  system clock, the only clock.
- `rst`  in  1  reset; **synchronous, active-high**.
- `req_i`  in  1  read request; held until granted.
- `addr_i`  in  24  flash byte address; `[1:0]` ignored and forced to 0.
- `quad_en_i`  in  1  1 = use 0x6B quad read; sampled at grant.
- `gnt_o`  out  1  one-cycle accept pulse; `addr_i` and `quad_en_i` are captured on it.
- `rvalid_o`  out  1  one-cycle pulse; `rdata_o` is valid in that cycle.
- `rdata_o`  out  32  read data; holds its value until the next `rvalid_o`.
- `busy_o`  out  1  high from the grant cycle until the CS_HIGH gap ends.
- `sck_o`  out  1  SPI clock, mode 0.
- `cs_n_o`  out  1  chip select, active low.
- `dq_o`  out  4  pad output data.
- `dq_oe`  out  4  pad output enables.
- `dq_i`  in  4  pad input data.

## Operation
- **Reset values:** `cs_n_o`=1, `sck_o`=0, `dq_o`=0, `dq_oe`=0, `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `busy_o`=0, FSM=IDLE.
- **FSM:** IDLE → CMD (8 SCK) → ADDR (24 SCK) → [DUMMY (8 SCK), quad only] → DATA (32 SCK single / 8 SCK quad) → GAP (CS_HIGH clk) → IDLE.
- **Grant:** `gnt_o` = `req_i` while in IDLE, registered as a pulse. There is at most one outstanding request. Dropping `req_i` before grant has no effect.
- **CMD/ADDR:** MSB first on `dq_o[0]`.
  - `dq_oe`=4'b1101 and `dq_o[3:2]`=2'b11, which keeps WP#/HOLD# high.
- **Single-mode DATA:** `dq_oe` stays 4'b1101. One bit is sampled per SCK from `dq_i[1]`.
- **Quad DUMMY/DATA:** `dq_oe`=4'b0000. One nibble is sampled per SCK from `dq_i[3:0]`, high nibble first.
- **Byte assembly:** the k-th received byte goes to `rdata_o[8k+7:8k]` (little-endian).
- **Mid-transfer reset:** abort. In the next cycle `cs_n_o`=1, `sck_o`=0 and `dq_oe`=0. No `rvalid_o` is issued.
- **`req_i` during a transfer or GAP:** ignored until IDLE.

## Timing
- **Grant and CS assertion:** grant happens in cycle G. At G+1, `cs_n_o` falls, `sck_o`=0, and bit 7 of the opcode is on `dq_o[0]`.
- **SCK period:** 2·CLK_DIV clk. `sck_o` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
- **Output updates:** outputs change only on the clk edge where `sck_o` goes low, or at G+1.
- **Sampling:** `dq_i` is captured on the clk edge where `sck_o` goes high.
- **End of transfer:** after the last SCK high phase, in cycle R = G+1+2·CLK_DIV·N, all of the following happen together:
  - `sck_o` returns low;
  - `cs_n_o` rises;
  - `dq_oe` goes to 0;
  - `rvalid_o` pulses.
- **N (SCK count):** 64 single, 48 quad. With CLK_DIV=1, R = G+129 single and G+97 quad.
- **Next grant:** earliest at R+CS_HIGH. `busy_o` falls in that same cycle.
- **Width rule:** `addr_i` is 24 bits. There is no wrap detection; the flash wraps internally at its size.

## Structure
- **Package `zr_qspi_pkg`:**
  - FSM state enum `qspi_state_e`;
  - opcode constants `QSPI_CMD_READ`=8'h03 and `QSPI_CMD_QREAD`=8'h6B;
  - phase length constants (CMD 8, ADDR 24, DUMMY 8);
  - lane-enable constants `QSPI_OE_SINGLE`=4'b1101 and `QSPI_OE_QUAD_IN`=4'b0000.
- **Sub-module `zr_qspi_sck_gen`:**
  - divider counter that produces `sck_o`;
  - one-cycle `rise_stb`/`fall_stb` strobes;
  - `run`/`stop` controls.
- **Top level:** FSM, bit counter (6 bits), 32-bit shift-out/shift-in registers and the handshake logic.

## Test plan
- **Single read:** flash bytes 0..3 = aa 55 81 0f, `req_i` with `addr_i`=0, `quad_en_i`=0, CLK_DIV=1 → `gnt_o` at G; bus shows 0x03, 0x000000; `rvalid_o` at G+129 with `rdata_o`=0x0f8155aa.
- **Quad read:** same data with `quad_en_i`=1 → opcode 0x6B, 8 dummy SCK, `dq_oe`=0 during dummy/data; `rvalid_o` at G+97 with `rdata_o`=0x0f8155aa.
- **Divider and alignment:** CLK_DIV=3, `addr_i`=0x000006 → SCK high/low 3 clk each; address on bus is 0x000004 (low bits forced); `rvalid_o` at G+1+6·64.
- **Back-to-back:** `req_i` held high continuously, CS_HIGH=2 → second `gnt_o` exactly R+2; `cs_n_o` high for exactly 2 clk between transactions.
- **Reset mid-ADDR:** `rst` asserted 20 clk after grant → next cycle `cs_n_o`=1, `sck_o`=0, `dq_oe`=0; no `rvalid_o`; a fresh request afterwards completes correctly.
- **Request withdrawn:** `req_i` pulsed while busy, then dropped before IDLE → no extra `gnt_o` and no extra transaction.
